// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the architectural HI/LO
// registers. One shift-add (mult) or restoring-subtract (div) step per cycle,
// WIDTH steps, followed by a sign-correction cycle. Results land in HI/LO on
// the FIX->DONE edge; done pulses for one cycle afterwards.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        launch op (accepted only when not busy)
//   op           00 mult, 01 multu, 10 div, 11 divu
//   srca, srcb   multiplicand/dividend, multiplier/divisor
//   abort        cancel in-flight op; also suppresses a start in IDLE/DONE
//   mthi, mtlo   write wdata into HI / LO when not busy
//   wdata        data for mthi/mtlo
//   busy         op in flight (RUN or FIX)
//   done         one-cycle pulse after HI/LO were updated by an op
//   div_by_zero  qualified by done; completed divide had srcb==0
//   hi, lo       architectural HI/LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_lo;   // negate product / quotient
  logic             r_neg_r;    // negate remainder
  logic             r_bzero;
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;      // upper half: product high / partial remainder
  logic [WIDTH-1:0] r_quo;      // lower half: multiplier / dividend -> quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dshift;
  logic             w_dfits;
  logic [WIDTH-1:0] w_dsub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_commit;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && !abort) w_next = S_RUN;
      S_RUN: begin
        if (abort)              w_next = S_IDLE;
        else if (r_cnt == '0)   w_next = S_FIX;
      end
      S_FIX:  w_next = abort ? S_IDLE : S_DONE;
      S_DONE: w_next = (start && !abort) ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state == S_RUN) || (r_state == S_FIX);
    done        = (r_state == S_DONE);
    div_by_zero = (r_state == S_DONE) && r_dbz;
  end

  // ---------------------------------------------------------------- operand prep
  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !abort;
  assign w_a_neg  = SIGNED && !op[0] && srca[WIDTH-1];
  assign w_b_neg  = SIGNED && !op[0] && srcb[WIDTH-1];
  assign w_a_mag  = w_a_neg ? ('0 - srca) : srca;
  assign w_b_mag  = w_b_neg ? ('0 - srcb) : srcb;

  // ---------------------------------------------------------------- step logic
  // Multiply: conditionally add multiplicand to the high half, then shift the
  // {carry, high, low} triple right by one.
  assign w_madd = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : '0);

  // Restoring divide: shift next dividend bit into the partial remainder and
  // subtract the divisor when it fits. Only the low WIDTH bits of the
  // difference are kept: whenever it fits, the true remainder is < divisor.
  // With a zero divisor every step "fits"; the result is overridden in FIX.
  assign w_dshift = {r_rem, r_quo[WIDTH-1]};
  assign w_dfits  = (w_dshift >= {1'b0, r_b});
  assign w_dsub   = w_dshift[WIDTH-1:0] - r_b;

  // ---------------------------------------------------------------- sign fix
  // MIN / -1 needs no special case: |MIN| / 1 yields the unsigned pattern of
  // MIN, and the quotient sign is positive, so lo=MIN and hi=0 fall out.
  assign w_prod     = {r_rem, r_quo};
  assign w_prod_fix = r_neg_lo ? ('0 - w_prod) : w_prod;
  assign w_q_fix    = r_neg_lo ? ('0 - r_quo) : r_quo;
  assign w_r_fix    = r_neg_r  ? ('0 - r_rem) : r_rem;

  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_bzero) begin
        w_res_hi = r_srca;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_r_fix;
        w_res_lo = w_q_fix;
      end
    end
  end

  assign w_commit = (r_state == S_FIX) && !abort;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_srca   <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
    end else if (w_accept) begin
      r_cnt    <= CW'(WIDTH - 1);
      r_is_div <= op[1];
      r_neg_lo <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_bzero  <= (srcb == '0);
      r_srca   <= srca;
      r_b      <= w_b_mag;
      r_rem    <= '0;
      r_quo    <= w_a_mag;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_is_div) begin
        r_rem <= w_dfits ? w_dsub : w_dshift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_dfits};
      end else begin
        {r_rem, r_quo} <= {w_madd, r_quo[WIDTH-1:1]};
      end
    end
  end

  // ---------------------------------------------------------------- HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_dbz <= 1'b0;
    end else if (w_commit) begin
      r_hi  <= w_res_hi;
      r_lo  <= w_res_lo;
      r_dbz <= r_is_div && r_bzero;
    end else if (!busy) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
